computer_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit computer. It has A/B accumulators, a registered ZNCV status register and a program counter. Instructions run through a FETCH/EXEC/MEM state machine. Instruction memory and data memory are external: instruction fetch is combinational-read, and data memory uses a req/ack handshake so it can have variable latency.

---
 rtl/computer_mc.sv | 204 ++++++++++++++++++++
 tb/tb_computer_mc.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computer_mc.sv
// Multi-cycle accumulator computer: FETCH/EXEC/MEM sequencer with A/B registers, ZNCV flags,
// combinational instruction fetch and a req/ack data-memory port.
module computer_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OPC_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [OPC_W+DATA_W-1:0]   imem_data,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic [DATA_W-1:0]         dmem_wdata,
  input  logic [DATA_W-1:0]         dmem_rdata,
  input  logic                      dmem_ack,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         regA_out,
  output logic [DATA_W-1:0]         regB_out,
  output logic [DATA_W-1:0]         alu_out,
  output logic [3:0]                status_out,
  output logic                      halted
);

  localparam int unsigned IW = OPC_W + DATA_W;

  localparam logic [OPC_W-1:0] OpMovAB = OPC_W'(7'h01);
  localparam logic [OPC_W-1:0] OpMovBA = OPC_W'(7'h02);
  localparam logic [OPC_W-1:0] OpLdiA  = OPC_W'(7'h03);
  localparam logic [OPC_W-1:0] OpLdiB  = OPC_W'(7'h04);
  localparam logic [OPC_W-1:0] OpAddB  = OPC_W'(7'h05);
  localparam logic [OPC_W-1:0] OpAddK  = OPC_W'(7'h06);
  localparam logic [OPC_W-1:0] OpSubB  = OPC_W'(7'h07);
  localparam logic [OPC_W-1:0] OpSubK  = OPC_W'(7'h08);
  localparam logic [OPC_W-1:0] OpAnd   = OPC_W'(7'h09);
  localparam logic [OPC_W-1:0] OpOr    = OPC_W'(7'h0A);
  localparam logic [OPC_W-1:0] OpXor   = OPC_W'(7'h0B);
  localparam logic [OPC_W-1:0] OpCmp   = OPC_W'(7'h0C);
  localparam logic [OPC_W-1:0] OpJmp   = OPC_W'(7'h0D);
  localparam logic [OPC_W-1:0] OpJeq   = OPC_W'(7'h0E);
  localparam logic [OPC_W-1:0] OpJne   = OPC_W'(7'h0F);
  localparam logic [OPC_W-1:0] OpLdK   = OPC_W'(7'h10);
  localparam logic [OPC_W-1:0] OpStK   = OPC_W'(7'h11);
  localparam logic [OPC_W-1:0] OpLdB   = OPC_W'(7'h12);
  localparam logic [OPC_W-1:0] OpStB   = OPC_W'(7'h13);
  localparam logic [OPC_W-1:0] OpHalt  = OPC_W'(7'h7F);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [3:0]          status_q, status_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [OPC_W-1:0]    opc;
  logic [DATA_W-1:0]   k;
  logic [DATA_W-1:0]   alu_opnd, alu_res;
  logic [DATA_W:0]     add_full, sub_full;
  logic                alu_c, alu_v, flag_en;
  logic [ADDR_W+DATA_W-1:0] k_ext, b_ext;
  logic [ADDR_W-1:0]   k_addr, b_addr, pc_inc;

  assign opc      = ir_q[IW-1:DATA_W];
  assign k        = ir_q[DATA_W-1:0];
  assign alu_opnd = (opc == OpAddK || opc == OpSubK || opc == OpCmp) ? k : b_q;
  assign add_full = {1'b0, a_q} + {1'b0, alu_opnd};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_full = {1'b0, a_q} - {1'b0, alu_opnd};

  // Zero-extend then truncate so any DATA_W/ADDR_W ratio works.
  assign k_ext  = {{ADDR_W{1'b0}}, k};
  assign b_ext  = {{ADDR_W{1'b0}}, b_q};
  assign k_addr = k_ext[ADDR_W-1:0];
  assign b_addr = b_ext[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    flag_en = 1'b0;
    case (opc)
      OpMovAB:         alu_res = b_q;
      OpMovBA:         alu_res = a_q;
      OpLdiA, OpLdiB:  alu_res = k;
      OpAddB, OpAddK: begin
        alu_res = add_full[DATA_W-1:0];
        alu_c   = add_full[DATA_W];
        alu_v   = (a_q[DATA_W-1] == alu_opnd[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != a_q[DATA_W-1]);
        flag_en = 1'b1;
      end
      OpSubB, OpSubK, OpCmp: begin
        alu_res = sub_full[DATA_W-1:0];
        alu_c   = sub_full[DATA_W];
        alu_v   = (a_q[DATA_W-1] != alu_opnd[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != a_q[DATA_W-1]);
        flag_en = 1'b1;
      end
      OpAnd: begin alu_res = a_q & b_q; flag_en = 1'b1; end
      OpOr:  begin alu_res = a_q | b_q; flag_en = 1'b1; end
      OpXor: begin alu_res = a_q ^ b_q; flag_en = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    status_d = status_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      StFetch: begin
        ir_d    = imem_data;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        if (flag_en) status_d = {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
        case (opc)
          OpMovAB, OpLdiA, OpAddB, OpAddK, OpSubB, OpSubK, OpAnd, OpOr, OpXor: a_d = alu_res;
          OpMovBA, OpLdiB: b_d = alu_res;
          OpJmp: pc_d = k_addr;
          OpJeq: if (status_q[3])  pc_d = k_addr;
          OpJne: if (!status_q[3]) pc_d = k_addr;
          OpLdK, OpStK, OpLdB, OpStB: begin
            // PC advances only once the access completes.
            pc_d    = pc_q;
            state_d = StMem;
            req_d   = 1'b1;
            we_d    = (opc == OpStK) || (opc == OpStB);
            addr_d  = (opc == OpLdK || opc == OpStK) ? k_addr : b_addr;
            wdata_d = a_q;
          end
          OpHalt: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      StMem: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          pc_d    = pc_inc;
          state_d = StFetch;
          if (!we_q) a_d = dmem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ir_q     <= '0;
      status_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      status_q <= status_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign pc_out     = pc_q;
  assign regA_out   = a_q;
  assign regB_out   = b_q;
  assign alu_out    = alu_res;
  assign status_out = status_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_computer_mc.sv
// Bench for computer_mc: directed scenarios plus random programs checked against an
// instruction-level model of the ISA.
module tb_computer_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [14:0] imem_data;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  dmem_rdata = 8'h00;
  logic        dmem_ack = 1'b0;
  logic [7:0]  pc_out, regA_out, regB_out, alu_out;
  logic [3:0]  status_out;
  logic        halted;

  logic [14:0] imem [0:255];
  logic [7:0]  dmem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc, m_a, m_b;
  bit m_z, m_n, m_c, m_v;

  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  computer_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc_out     (pc_out),
    .regA_out   (regA_out),
    .regB_out   (regB_out),
    .alu_out    (alu_out),
    .status_out (status_out),
    .halted     (halted)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 15'h0000;
  endtask

  // Leaves time at mid-cycle with reset released; the next edge is the first FETCH.
  task automatic do_reset();
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
    m_pc = 0; m_a = 0; m_b = 0;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0;
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic test_reset();
    clear_imem();
    imem[0] = {7'h03, 8'h80};
    imem[1] = {7'h06, 8'h80};
    imem[2] = {7'h0D, 8'h00};
    do_reset();
    tick(4);
    n_checks++;
    if ({regA_out, status_out} !== {8'h00, 4'b1011}) begin
      n_fail++;
      $display("FAIL add_80_80: A/status=%h/%b want 00/1011", regA_out, status_out);
    end
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_out, regA_out, regB_out, status_out, dmem_req, halted} !== 30'h0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h A=%h B=%h st=%b req=%b halt=%b want all 0",
               pc_out, regA_out, regB_out, status_out, dmem_req, halted);
    end
    #1 rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL first_fetch: imem_addr=%h want 00", imem_addr);
    end
    tick(1);
    n_checks++;
    if ({pc_out, regA_out} !== {8'h01, 8'h80}) begin
      n_fail++;
      $display("FAIL resume: pc/A=%h/%h want 01/80", pc_out, regA_out);
    end
  endtask

  task automatic test_add_overflow();
    clear_imem();
    imem[0] = {7'h03, 8'h7F};
    imem[1] = {7'h06, 8'h01};
    do_reset();
    tick(3);
    n_checks++;
    if (regA_out !== 8'h7F) begin
      n_fail++;
      $display("FAIL add_latency: A=%h want 7f after 3 cycles", regA_out);
    end
    n_checks++;
    if (alu_out !== 8'h80) begin
      n_fail++;
      $display("FAIL alu_out: got %h want 80", alu_out);
    end
    tick(1);
    n_checks++;
    if ({regA_out, status_out} !== {8'h80, 4'b0101}) begin
      n_fail++;
      $display("FAIL add_ovf: A/status=%h/%b want 80/0101", regA_out, status_out);
    end
  endtask

  task automatic test_sub_jeq();
    for (int t = 0; t < 2; t++) begin
      clear_imem();
      imem[0] = {7'h03, 8'h05};
      imem[1] = {7'h08, (t == 0) ? 8'h05 : 8'h04};
      imem[2] = {7'h0E, 8'h20};
      do_reset();
      tick(4);
      n_checks++;
      if (status_out !== ((t == 0) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL sub_flags%0d: status=%b want %b", t, status_out,
                 (t == 0) ? 4'b1000 : 4'b0000);
      end
      tick(2);
      n_checks++;
      if (pc_out !== ((t == 0) ? 8'h20 : 8'h03)) begin
        n_fail++;
        $display("FAIL jeq%0d: pc=%h want %h", t, pc_out, (t == 0) ? 8'h20 : 8'h03);
      end
    end
  endtask

  task automatic test_load_wait();
    clear_imem();
    imem[0] = {7'h04, 8'h40};
    imem[1] = {7'h12, 8'h00};
    do_reset();
    tick(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 8'h40}) begin
        n_fail++;
        $display("FAIL load_wait%0d: req/we/addr=%b/%b/%h want 1/0/40", i, dmem_req,
                 dmem_we, dmem_addr);
      end
      if (i < 3) tick(1);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 8'hA5;
    tick(1);
    dmem_ack = 1'b0;
    n_checks++;
    if ({dmem_req, regA_out, pc_out} !== {1'b0, 8'hA5, 8'h02}) begin
      n_fail++;
      $display("FAIL load_done: req/A/pc=%b/%h/%h want 0/a5/02", dmem_req, regA_out, pc_out);
    end
  endtask

  task automatic test_store_wrap();
    clear_imem();
    imem[0] = {7'h03, 8'h3C};
    imem[1] = {7'h11, 8'hFF};
    do_reset();
    tick(4);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 8'hFF, 8'h3C}) begin
      n_fail++;
      $display("FAIL store_req: req/we/addr/wdata=%b/%b/%h/%h want 1/1/ff/3c", dmem_req,
               dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    tick(1);
    dmem_ack = 1'b0;
    n_checks++;
    if ({dmem_req, pc_out, regA_out} !== {1'b0, 8'h02, 8'h3C}) begin
      n_fail++;
      $display("FAIL store_done: req/pc/A=%b/%h/%h want 0/02/3c", dmem_req, pc_out, regA_out);
    end
    clear_imem();
    imem[0] = {7'h0D, 8'hFF};
    do_reset();
    tick(2);
    n_checks++;
    if (pc_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL jmp_ff: pc=%h want ff", pc_out);
    end
    tick(2);
    n_checks++;
    if (pc_out !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h want 00", pc_out);
    end
  endtask

  task automatic test_halt();
    int bad;
    clear_imem();
    imem[0] = {7'h7F, 8'h00};
    do_reset();
    tick(2);
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt: halted=%b want 1", halted);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      dmem_ack = 1'($urandom_range(0, 1));
      tick(1);
      if (pc_out !== 8'h00 || dmem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    dmem_ack = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_frozen: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = {7'h03, 8'h11};
    imem[1] = {7'h12, 8'h00};
    do_reset();
    tick(4);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_pending: req=%b want 1", dmem_req);
    end
    tick(2);
    #2;
    dmem_ack = 1'b1;
    dmem_rdata = 8'hA5;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, regA_out} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_in_mem: req/A=%b/%h want 0/00", dmem_req, regA_out);
    end
    #10 rst_n = 1'b1;
    tick(1);
    dmem_ack = 1'b0;
    n_checks++;
    if ({dmem_req, regA_out, pc_out} !== {1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL abandoned_load: req/A/pc=%b/%h/%h want 0/00/00", dmem_req, regA_out,
               pc_out);
    end
  endtask

  // Runs the instruction at the model PC through the DUT and the model, then compares.
  task automatic exec_one();
    logic [14:0] ins;
    int opc, k, a, b, op, r, sv, res, addr, npc, lat;
    bit flags, is_mem, is_st;
    ins = imem[m_pc];
    opc = int'(ins[14:8]);
    k = int'(ins[7:0]);
    a = m_a; b = m_b;
    flags = 0; is_mem = 0; is_st = 0; res = 0; addr = 0;
    npc = (m_pc + 1) % 256;
    case (opc)
      1: m_a = b;
      2: m_b = a;
      3: m_a = k;
      4: m_b = k;
      5, 6: begin
        op = (opc == 5) ? b : k;
        r = a + op;
        res = r % 256;
        m_c = (r > 255);
        sv = sgn(a) + sgn(op);
        m_v = (sv > 127) || (sv < -128);
        m_a = res;
        flags = 1;
      end
      7, 8, 12: begin
        op = (opc == 7) ? b : k;
        r = a - op;
        res = (r + 256) % 256;
        m_c = (a < op);
        sv = sgn(a) - sgn(op);
        m_v = (sv > 127) || (sv < -128);
        if (opc != 12) m_a = res;
        flags = 1;
      end
      9, 10, 11: begin
        res = (opc == 9) ? (a & b) : (opc == 10) ? (a | b) : (a ^ b);
        m_c = 0; m_v = 0;
        m_a = res;
        flags = 1;
      end
      13: npc = k;
      14: if (m_z) npc = k;
      15: if (!m_z) npc = k;
      16, 17, 18, 19: begin
        is_mem = 1;
        is_st = (opc == 17) || (opc == 19);
        addr = (opc <= 17) ? k : b;
        if (!is_st) m_a = int'(dmem[addr]);
      end
      default: ;
    endcase
    if (flags) begin
      m_z = (res == 0);
      m_n = (res >= 128);
    end
    // Acks during FETCH/EXEC must be ignored.
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = 8'($urandom);
    tick(2);
    dmem_ack = 1'b0;
    if (is_mem) begin
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, is_st, 8'(addr)} ||
          (is_st && dmem_wdata !== 8'(a))) begin
        n_fail++;
        $display("FAIL rnd_req pc=%0h op=%0h: req/we/addr/wd=%b/%b/%h/%h want 1/%b/%h/%h",
                 m_pc, opc, dmem_req, dmem_we, dmem_addr, dmem_wdata, is_st, 8'(addr), 8'(a));
      end
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        tick(1);
        n_checks++;
        if ({dmem_req, dmem_addr} !== {1'b1, 8'(addr)}) begin
          n_fail++;
          $display("FAIL rnd_hold: req/addr=%b/%h want 1/%h", dmem_req, dmem_addr, 8'(addr));
        end
      end
      dmem_ack = 1'b1;
      dmem_rdata = dmem[addr];
      tick(1);
      dmem_ack = 1'b0;
      if (is_st) dmem[addr] = 8'(a);
    end
    m_pc = npc;
    n_checks++;
    if ({pc_out, regA_out, regB_out, status_out, dmem_req, halted} !==
        {8'(m_pc), 8'(m_a), 8'(m_b), m_z, m_n, m_c, m_v, 2'b00}) begin
      n_fail++;
      $display("FAIL rnd_state op=%0h: pc/A/B/st=%h/%h/%h/%b req=%b want %h/%h/%h/%b req=0",
               opc, pc_out, regA_out, regB_out, status_out, dmem_req, 8'(m_pc), 8'(m_a),
               8'(m_b), {m_z, m_n, m_c, m_v});
    end
  endtask

  task automatic test_random();
    int opc;
    for (int i = 0; i < 256; i++) begin
      opc = $urandom_range(0, 20);
      if (opc == 20) opc = 7'h3A;
      imem[i] = {7'(opc), 8'($urandom)};
      dmem[i] = 8'($urandom);
    end
    do_reset();
    for (int n = 0; n < 400; n++) exec_one();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_jeq();
    test_load_wait();
    test_store_wrap();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
